// File: rtl/tqvp_vga_copper_pkg.sv
// Shared definitions for the VGA copper: opcodes, instruction
// field positions and the sequencer state encoding.
package tqvp_vga_copper_pkg;

   localparam logic [1:0] OP_WAIT  = 2'b00;
   localparam logic [1:0] OP_MOVE  = 2'b01;
   localparam logic [1:0] OP_WAITH = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   localparam int OP_HI = 15;
   localparam int OP_LO = 14;
   localparam int RA_HI = 13;
   localparam int RA_LO = 8;
   localparam int RD_HI = 7;
   localparam int RD_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WAIT_Y,
      S_WAIT_HB,
      S_HALT
   } state_t;

endpackage

// File: rtl/tqvp_vga_copper_list.sv
// Copper instruction store: one synchronous read port, one write port.
// A same-cycle write to the slot being read returns the old word.
module tqvp_vga_copper_list #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/tqvp_vga_copper.sv
// Display-list sequencer for the TinyQV VGA peripheral, plus the
// register-port arbiter shared with the CPU bus (CPU always wins).
module tqvp_vga_copper
   import tqvp_vga_copper_pkg::*;
#(
   parameter int LIST_DEPTH = 16,
   parameter int Y_W        = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          frame_start,
   input  logic [Y_W-1:0]                vga_y,
   input  logic                          vga_blank,
   input  logic                          list_we,
   input  logic [$clog2(LIST_DEPTH)-1:0] list_addr,
   input  logic [15:0]                   list_data,
   input  logic                          cpu_we,
   input  logic [5:0]                    cpu_addr,
   input  logic [7:0]                    cpu_data,
   output logic                          reg_we,
   output logic [5:0]                    reg_addr,
   output logic [7:0]                    reg_data,
   output logic                          busy,
   output logic [$clog2(LIST_DEPTH)-1:0] pc
);

   localparam int PW = $clog2(LIST_DEPTH);

   state_t      state, state_n;
   logic [PW-1:0] pc_n;
   logic [15:0] word;
   logic        blank_q;
   logic        hb_arm;
   logic        issue;
   logic        adv;
   logic [1:0]  op;

   tqvp_vga_copper_list #(
      .DEPTH (LIST_DEPTH),
      .AW    (PW)
   ) u_list (
      .clk     (clk),
      .rd_en   (state == S_FETCH),
      .rd_addr (pc),
      .rd_data (word),
      .we      (list_we),
      .wr_addr (list_addr),
      .wr_data (list_data)
   );

   assign op = word[OP_HI:OP_LO];

   always_comb begin
      state_n = state;
      pc_n    = pc;
      issue   = 1'b0;
      adv     = 1'b0;
      if (!enable) begin
         state_n = S_IDLE;
      end else if (frame_start) begin
         state_n = S_FETCH;
         pc_n    = '0;
      end else begin
         unique case (state)
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
               unique case (op)
                  OP_MOVE: begin
                     issue = !cpu_we;
                     adv   = !cpu_we;
                  end
                  OP_WAIT:  state_n = S_WAIT_Y;
                  OP_WAITH: state_n = S_WAIT_HB;
                  default:  state_n = S_HALT;
               endcase
            end
            S_WAIT_Y:
               adv = (vga_y >= word[Y_W-1:0]);
            // hb_arm masks an edge coinciding with the entry cycle
            S_WAIT_HB:
               adv = hb_arm && vga_blank && !blank_q;
            default: ;
         endcase
         if (adv) begin
            if (pc == PW'(LIST_DEPTH - 1)) begin
               state_n = S_HALT;
            end else begin
               state_n = S_FETCH;
               pc_n    = pc + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= '0;
         blank_q  <= 1'b0;
         hb_arm   <= 1'b0;
         reg_we   <= 1'b0;
         reg_addr <= '0;
         reg_data <= '0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         blank_q <= vga_blank;
         hb_arm  <= (state == S_WAIT_HB);
         reg_we  <= cpu_we | issue;
         if (cpu_we) begin
            reg_addr <= cpu_addr;
            reg_data <= cpu_data;
         end else if (issue) begin
            reg_addr <= word[RA_HI:RA_LO];
            reg_data <= word[RD_HI:RD_LO];
         end
      end
   end

   assign busy = (state == S_FETCH) || (state == S_EXEC) ||
                 (state == S_WAIT_Y) || (state == S_WAIT_HB);

endmodule

// File: tb/tb_tqvp_vga_copper.sv
// Directed bench for the VGA copper: list execution, waits,
// CPU arbitration, enable drop and reset.
module tb_tqvp_vga_copper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       frame_start;
   logic [9:0] vga_y;
   logic       vga_blank;
   logic       list_we;
   logic [3:0] list_addr;
   logic [15:0] list_data;
   logic       cpu_we;
   logic [5:0] cpu_addr;
   logic [7:0] cpu_data;
   logic       reg_we;
   logic [5:0] reg_addr;
   logic [7:0] reg_data;
   logic       busy;
   logic [3:0] pc;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tqvp_vga_copper #(
      .LIST_DEPTH (16),
      .Y_W        (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_start (frame_start),
      .vga_y       (vga_y),
      .vga_blank   (vga_blank),
      .list_we     (list_we),
      .list_addr   (list_addr),
      .list_data   (list_data),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .busy        (busy),
      .pc          (pc)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [15:0] d);
      list_we   = 1'b1;
      list_addr = 4'(a);
      list_data = d;
      tick();
      list_we   = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic count_we(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (reg_we) cnt++;
      end
   endtask

   function automatic logic [15:0] mv(input logic [5:0] a,
                                      input logic [7:0] d);
      return {2'b01, a, d};
   endfunction

   function automatic logic [15:0] wt(input logic [9:0] l);
      return {2'b00, 4'b0000, l};
   endfunction

   localparam logic [15:0] WH = 16'h8000;
   localparam logic [15:0] EN = 16'hC000;

   initial begin
      int n;
      int first_y;
      int nw;
      rst_n       = 1'b0;
      enable      = 1'b0;
      frame_start = 1'b0;
      vga_y       = '0;
      vga_blank   = 1'b0;
      list_we     = 1'b0;
      list_addr   = '0;
      list_data   = '0;
      cpu_we      = 1'b0;
      cpu_addr    = '0;
      cpu_data    = '0;
      repeat (3) tick();
      chk("rst_we", reg_we, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_data", reg_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pc", pc, 0);
      rst_n  = 1'b1;
      enable = 1'b1;

      // single MOVE then END
      load(0, mv(6'h30, 8'h15));
      load(1, EN);
      pulse_fs();
      chk("t1_busy_fetch", busy, 1);
      tick();
      chk("t1_we_exec", reg_we, 0);
      tick();
      chk("t1_we", reg_we, 1);
      chk("t1_addr", reg_addr, 32'h30);
      chk("t1_data", reg_data, 32'h15);
      count_we(10, n);
      chk("t1_nomore", n, 0);
      chk("t1_halt_busy", busy, 0);

      // WAIT on line 100
      load(0, wt(10'd100));
      load(1, mv(6'h31, 8'h3F));
      load(2, EN);
      pulse_fs();
      first_y = -1;
      nw = 0;
      for (int y = 90; y <= 110; y++) begin
         vga_y = 10'(y);
         tick();
         if (reg_we) begin
            nw++;
            if (first_y < 0) first_y = y;
            chk("t2_addr", reg_addr, 32'h31);
            chk("t2_data", reg_data, 32'h3F);
         end
      end
      chk("t2_when", first_y, 102);
      chk("t2_count", nw, 1);

      // WAIT on unreachable line 700
      load(0, wt(10'd700));
      vga_y = '0;
      pulse_fs();
      nw = 0;
      for (int y = 0; y < 600; y++) begin
         vga_y = 10'(y);
         tick();
         if (reg_we) nw++;
      end
      chk("t2b_nowrite", nw, 0);
      chk("t2b_busy", busy, 1);
      chk("t2b_pc", pc, 0);
      vga_y = '0;
      pulse_fs();
      chk("t2b_fs_pc", pc, 0);
      chk("t2b_fs_busy", busy, 1);

      // CPU wins against a MOVE in EXEC
      load(0, mv(6'h30, 8'h15));
      load(1, EN);
      pulse_fs();
      tick();
      cpu_we   = 1'b1;
      cpu_addr = 6'h3F;
      cpu_data = 8'h01;
      tick();
      cpu_we   = 1'b0;
      chk("t3_cpu_we", reg_we, 1);
      chk("t3_cpu_addr", reg_addr, 32'h3F);
      chk("t3_cpu_data", reg_data, 32'h01);
      chk("t3_pc_held", pc, 0);
      tick();
      chk("t3_cop_we", reg_we, 1);
      chk("t3_cop_addr", reg_addr, 32'h30);
      chk("t3_cop_data", reg_data, 32'h15);
      chk("t3_pc_adv", pc, 1);
      tick();
      chk("t3_we_low", reg_we, 0);

      // 16 MOVEs, no END
      for (int i = 0; i < 16; i++)
         load(i, mv(6'(i), 8'(i * 3 + 1)));
      pulse_fs();
      nw = 0;
      for (int t = 1; t <= 50; t++) begin
         tick();
         if (reg_we) begin
            chk("t4_time", t, 2 + 2 * nw);
            chk("t4_addr", reg_addr, 32'(nw & 63));
            chk("t4_data", reg_data, 32'((nw * 3 + 1) & 255));
            nw++;
         end
      end
      chk("t4_count", nw, 16);
      chk("t4_busy", busy, 0);

      // WAITH: blank high on entry, then restart, then a real edge
      load(0, WH);
      load(1, mv(6'h32, 8'hAA));
      load(2, EN);
      vga_blank = 1'b1;
      pulse_fs();
      count_we(6, n);
      chk("t5_noedge", n, 0);
      chk("t5_busy", busy, 1);
      chk("t5_pc", pc, 0);
      pulse_fs();
      chk("t5_restart_pc", pc, 0);
      chk("t5_restart_busy", busy, 1);
      tick();
      tick();
      vga_blank = 1'b0;
      tick();
      vga_blank = 1'b1;
      tick();
      chk("t5_fetch_we", reg_we, 0);
      tick();
      tick();
      chk("t5_we", reg_we, 1);
      chk("t5_addr", reg_addr, 32'h32);
      chk("t5_data", reg_data, 32'hAA);
      vga_blank = 1'b0;

      // enable dropped while a MOVE sits in EXEC
      for (int i = 0; i < 16; i++)
         load(i, mv(6'(i), 8'(i * 3 + 1)));
      pulse_fs();
      repeat (5) tick();
      enable = 1'b0;
      tick();
      chk("t6_no_issue", reg_we, 0);
      chk("t6_idle", busy, 0);
      cpu_we   = 1'b1;
      cpu_addr = 6'h05;
      cpu_data = 8'h5A;
      tick();
      cpu_we   = 1'b0;
      chk("t6_cpu_we", reg_we, 1);
      chk("t6_cpu_addr", reg_addr, 32'h05);
      chk("t6_cpu_data", reg_data, 32'h5A);
      count_we(10, n);
      chk("t6_quiet", n, 0);
      enable = 1'b1;

      // reset asserted during EXEC of a MOVE
      pulse_fs();
      tick();
      rst_n = 1'b0;
      tick();
      chk("t7_we", reg_we, 0);
      chk("t7_addr", reg_addr, 0);
      chk("t7_data", reg_data, 0);
      chk("t7_busy", busy, 0);
      chk("t7_pc", pc, 0);
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
